avl_pkt_arbiter: RTL and testbench
==================================

# avl_pkt_arbiter

Packet-atomic round-robin arbiter that shares the single Avalon-ST-style port into the DDR3 frame-buffer controller between NUM_REQ NoC-side requesters (each already retimed by its own NoC-to-Avalon shim). A grant is held from start-of-packet to end-of-packet. Backpressure (avl_waitrequest) is forwarded only to the granted requester. The block sits between the per-port shims and the DDR3 controller command/data interface.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- WIDTH_PKT, 546, data word width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_data  in  NUM_REQ*WIDTH_PKT  packed words; requester i at [i*WIDTH_PKT +: WIDTH_PKT]
- req_valid  in  NUM_REQ  word valid per requester
- req_sop  in  NUM_REQ  start of packet
- req_eop  in  NUM_REQ  end of packet
- req_ready  out  NUM_REQ  word accepted from requester i this cycle
- avl_data  out  WIDTH_PKT  granted word
- avl_valid  out  1  granted word valid
- avl_sop  out  1  granted sop
- avl_eop  out  1  granted eop
- avl_waitrequest  in  1  controller stall; transfer = avl_valid & ~avl_waitrequest
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester

## Operation
- FSM states: IDLE, BUSY.
- IDLE: candidates = req_valid & req_sop. If any, pick the first candidate at or after rr_ptr (wrapping), register grant_id, go BUSY. avl_valid=0.
- IDLE, valid word without sop (protocol error): req_ready[i]=1, word dropped; sop-valid requesters are not readied in IDLE.
- BUSY: avl_data/valid/sop/eop = req_* of grant_id; req_ready[grant_id] = ~avl_waitrequest, all other req_ready=0.
- BUSY, transfer with avl_eop=1: rr_ptr <= grant_id+1 (wrap to 0 at NUM_REQ), go IDLE.
- Single-word packet (sop & eop together): one BUSY cycle if not stalled, then IDLE.
- Granted requester with valid low in BUSY: avl_valid=0, grant held (no timeout).

## Timing
- Reset: state IDLE, rr_ptr 0, grant_id 0, avl_valid/sop/eop 0, avl_data 0, req_ready all 0.
- Arbitration latency: sop seen in IDLE at cycle N → avl_valid at N+1.
- One IDLE bubble between consecutive packets: min 1 cycle gap at avl port.
- BUSY data path and req_ready combinational (zero latency); a stalled word remains presented unchanged by the requester.
- Reset mid-packet: next cycle IDLE, avl_valid 0; remainder of the truncated packet at the requester is dropped as non-sop words.
- Simultaneous eop transfer and new sop from another requester: new arbitration occurs in the following IDLE cycle using the updated rr_ptr.

## Configuration
- AVL_ARB_STATS_EN defined: per-requester 16-bit pkt_cnt (increments on eop transfer, wraps at 0xFFFF→0) and a 16-bit drop_cnt (increments on each dropped non-sop word, saturates at 0xFFFF). Outputs: pkt_cnt (NUM_REQ*16), drop_cnt (16). All reset to 0.
- Undefined: counters and their ports absent; functional behaviour identical.

## Structure
- Package avl_arb_pkg: state enum (IDLE, BUSY), MAX_REQ=4, counter width constant 16.
- Sub-module rr_pick: combinational round-robin picker (request vector, pointer → one-hot grant + index + any).

## Test plan
- Requesters 0 and 1 send 3-word packets simultaneously after reset → req 0 granted first (rr_ptr 0), then req 1; 3+3 words out in order, with one gap cycle.
- Both requesters stream continuously → grants alternate 0,1,0,1; no interleaving of words within a packet.
- avl_waitrequest held high for 4 cycles mid-packet → avl_data stable, req_ready[g]=0 for those cycles, no word lost or duplicated.
- Requester 1 sends a non-sop word while IDLE → word dropped (req_ready[1]=1), no output; drop_cnt=1 with AVL_ARB_STATS_EN.
- rst asserted on word 2 of a 4-word packet → avl_valid=0 the next cycle; next sop arbitrated from rr_ptr 0.
- Single-word packets (sop=eop=1) from all 4 requesters (NUM_REQ=4) → grant order 0,1,2,3, pkt_cnt each 1.

Source files
------------

// File: rtl/avl_arb_pkg.sv
// Shared types and constants for the Avalon-ST packet arbiter.
package avl_arb_pkg;

    // Arbiter FSM: IDLE arbitrates between sop-valid requesters, BUSY owns the port.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Largest supported requester count.
    localparam int MAX_REQ = 4;

    // Width of the optional statistics counters.
    localparam int CNT_W = 16;

endpackage

// File: rtl/avl_pkt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first request at or
// after ptr_i (wrapping) as a one-hot grant plus its index, and whether any
// request is present.
module rr_pick
    import avl_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Rotate requests so that bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        dbl   = {req_i, req_i} >> ptr_i;
        rot   = dbl[N-1:0];
        sum   = '0;
        idx_o = '0;
        gnt_o = '0;
        any_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr_i} + (IW + 1)'(i);
                if (sum >= (IW + 1)'(N)) begin
                    sum = sum - (IW + 1)'(N);
                end
                idx_o = sum[IW-1:0];
            end
        end
        if (any_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/avl_pkt_arbiter.sv
// avl_pkt_arbiter: packet-atomic round-robin arbiter sharing one Avalon-ST
// port between NUM_REQ requesters. A grant is held from sop to eop and
// waitrequest is forwarded only to the granted requester.
// Optional statistics counters are enabled with `define AVL_ARB_STATS_EN.
module avl_pkt_arbiter
    import avl_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int WIDTH_PKT = 546,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*WIDTH_PKT-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_sop,
    input  logic [NUM_REQ-1:0]           req_eop,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [WIDTH_PKT-1:0]         avl_data,
    output logic                         avl_valid,
    output logic                         avl_sop,
    output logic                         avl_eop,
    input  logic                         avl_waitrequest,
`ifdef AVL_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
`endif
    output logic [IDX_W-1:0]             grant_id
);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   grant_id_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               xfer_eop;

    assign cand     = req_valid & req_sop;
    assign grant_id = grant_id_q;
    assign xfer_eop = (state_q == BUSY) & avl_valid & avl_eop & ~avl_waitrequest;
    assign rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req_i (cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Port mux: in BUSY pass the granted requester through with zero latency; in IDLE drain stray non-sop words.
    always_comb begin
        avl_data  = '0;
        avl_valid = 1'b0;
        avl_sop   = 1'b0;
        avl_eop   = 1'b0;
        req_ready = '0;
        if (!rst) begin
            if (state_q == BUSY) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_oh_q[i]) begin
                        avl_data  = req_data[i*WIDTH_PKT +: WIDTH_PKT];
                        avl_valid = req_valid[i];
                        avl_sop   = req_sop[i];
                        avl_eop   = req_eop[i];
                    end
                end
                req_ready = grant_oh_q & {NUM_REQ{~avl_waitrequest}};
            end else begin
                req_ready = req_valid & ~req_sop;
            end
        end
    end

    // Arbitration FSM: grant on sop in IDLE, release and advance the pointer on the eop transfer.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update from the same pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_id_q <= pick_idx;
                        grant_oh_q <= pick_gnt;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_eop) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AVL_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0]              drop_cnt_q;
    logic [CNT_W-1:0]              drop_cnt_d;
    logic [CNT_W:0]                drop_sum;
    logic [NUM_REQ-1:0]            drop_vec;

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign drop_vec = (state_q == IDLE) ? req_ready : '0;

    // Saturating add of every word dropped this cycle.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drop_vec[i]) begin
                drop_sum = drop_sum + (CNT_W + 1)'(1);
            end
        end
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Per-requester packet counters (wrapping) and the shared drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer_eop && grant_oh_q[i]) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_avl_pkt_arbiter.sv
// Self-checking bench for avl_pkt_arbiter (NUM_REQ=4). Cycle-level vector
// table plus hand-written single-word and streaming sequences. Counter checks
// are included when AVL_ARB_STATS_EN is defined.
module tb_avl_pkt_arbiter;
    import avl_arb_pkg::*;

    localparam int NR = MAX_REQ;
    localparam int W  = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_valid, req_sop, req_eop, req_ready;
    logic [W-1:0]    avl_data;
    logic            avl_valid, avl_sop, avl_eop, avl_waitrequest;
    logic [1:0]      grant_id;
`ifdef AVL_ARB_STATS_EN
    logic [NR*CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0]    drop_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    avl_pkt_arbiter #(.NUM_REQ(NR), .WIDTH_PKT(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_data        (req_data),
        .req_valid       (req_valid),
        .req_sop         (req_sop),
        .req_eop         (req_eop),
        .req_ready       (req_ready),
        .avl_data        (avl_data),
        .avl_valid       (avl_valid),
        .avl_sop         (avl_sop),
        .avl_eop         (avl_eop),
        .avl_waitrequest (avl_waitrequest),
`ifdef AVL_ARB_STATS_EN
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt),
`endif
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        bit         rst;
        logic [3:0] v, s, e;
        logic [31:0] tags;   // byte i is the tag of requester i
        bit         wr;
        bit         ev, es, ee;
        int         src;
        logic [7:0] etag;
        bit         dz;      // avl_data must be zero when not valid
        logic [3:0] erdy;
        logic [1:0] egid;
    } vec_t;

    vec_t vecs[$];
    int   order[$];

    function automatic logic [W-1:0] word(int src, logic [7:0] tag);
        return {48'h0, src[7:0], tag};
    endfunction

    function automatic vec_t mk(string nm, bit r, logic [3:0] v, logic [3:0] s, logic [3:0] e,
                                logic [31:0] tags, bit wr, bit ev, bit es, bit ee, int src,
                                logic [7:0] etag, bit dz, logic [3:0] erdy, logic [1:0] egid);
        vec_t x;
        x.nm = nm; x.rst = r; x.v = v; x.s = s; x.e = e; x.tags = tags; x.wr = wr;
        x.ev = ev; x.es = es; x.ee = ee; x.src = src; x.etag = etag; x.dz = dz;
        x.erdy = erdy; x.egid = egid;
        return x;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                         input logic [31:0] tags, input bit wr);
        rst             = r;
        req_valid       = v;
        req_sop         = s;
        req_eop         = e;
        avl_waitrequest = wr;
        for (int i = 0; i < NR; i++) begin
            req_data[i*W +: W] = word(i, tags[i*8 +: 8]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pend, cyc, k, pkt;
        int w[2];
        logic [3:0]  v, s, e;
        logic [31:0] tags;

        //           name            rst v        s        e        tags          wr ev es ee src etag   dz erdy     gid
        vecs.push_back(mk("rst",        1, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 0));
        vecs.push_back(mk("t1_arb",     0, 4'b0011, 4'b0011, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 0));
        vecs.push_back(mk("t1_p0w0",    0, 4'b0011, 4'b0011, 4'b0000, 32'h0,        0, 1, 1, 0, 0, 8'h00, 0, 4'b0001, 0));
        vecs.push_back(mk("t1_p0w1",    0, 4'b0011, 4'b0010, 4'b0000, 32'h0000_0001, 0, 1, 0, 0, 0, 8'h01, 0, 4'b0001, 0));
        vecs.push_back(mk("t1_p0w2",    0, 4'b0011, 4'b0010, 4'b0001, 32'h0000_0002, 0, 1, 0, 1, 0, 8'h02, 0, 4'b0001, 0));
        vecs.push_back(mk("t1_gap",     0, 4'b0010, 4'b0010, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 0));
        vecs.push_back(mk("t1_p1w0",    0, 4'b0010, 4'b0010, 4'b0000, 32'h0,        0, 1, 1, 0, 1, 8'h00, 0, 4'b0010, 1));
        vecs.push_back(mk("t1_p1w1",    0, 4'b0010, 4'b0000, 4'b0000, 32'h0000_0100, 0, 1, 0, 0, 1, 8'h01, 0, 4'b0010, 1));
        vecs.push_back(mk("t1_p1w2",    0, 4'b0010, 4'b0000, 4'b0010, 32'h0000_0200, 0, 1, 0, 1, 1, 8'h02, 0, 4'b0010, 1));
        vecs.push_back(mk("idle",       0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 1));
        vecs.push_back(mk("ws_arb",     0, 4'b0100, 4'b0100, 4'b0000, 32'h0010_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 1));
        vecs.push_back(mk("ws_w0",      0, 4'b0100, 4'b0100, 4'b0000, 32'h0010_0000, 0, 1, 1, 0, 2, 8'h10, 0, 4'b0100, 2));
        vecs.push_back(mk("ws_vlow",    0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 0, 4'b0100, 2));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk("ws_stall", 0, 4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 1, 1, 0, 0, 2, 8'h11, 0, 4'b0000, 2));
        end
        vecs.push_back(mk("ws_w1",      0, 4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 0, 1, 0, 0, 2, 8'h11, 0, 4'b0100, 2));
        vecs.push_back(mk("ws_eopstall",0, 4'b0100, 4'b0000, 4'b0100, 32'h0012_0000, 1, 1, 0, 1, 2, 8'h12, 0, 4'b0000, 2));
        vecs.push_back(mk("ws_eop",     0, 4'b0100, 4'b0000, 4'b0100, 32'h0012_0000, 0, 1, 0, 1, 2, 8'h12, 0, 4'b0100, 2));
        vecs.push_back(mk("drop",       0, 4'b0010, 4'b0000, 4'b0000, 32'h0000_7700, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0010, 2));
        vecs.push_back(mk("sop_no_rdy", 0, 4'b1000, 4'b1000, 4'b0000, 32'h3000_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 2));
        vecs.push_back(mk("rp_w0",      0, 4'b1000, 4'b1000, 4'b0000, 32'h3000_0000, 0, 1, 1, 0, 3, 8'h30, 0, 4'b1000, 3));
        vecs.push_back(mk("rp_rst",     1, 4'b1000, 4'b0000, 4'b0000, 32'h3100_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 3));
        vecs.push_back(mk("rp_drop1",   0, 4'b1000, 4'b0000, 4'b0000, 32'h3100_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b1000, 0));
        vecs.push_back(mk("rp_drop2",   0, 4'b1000, 4'b0000, 4'b0000, 32'h3200_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b1000, 0));
        vecs.push_back(mk("rp_drop3",   0, 4'b1000, 4'b0000, 4'b1000, 32'h3300_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b1000, 0));
        vecs.push_back(mk("rp_arb",     0, 4'b1010, 4'b1010, 4'b1010, 32'h5000_4000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 0));
        vecs.push_back(mk("rp_g1",      0, 4'b1010, 4'b1010, 4'b1010, 32'h5000_4000, 0, 1, 1, 1, 1, 8'h40, 0, 4'b0010, 1));
        vecs.push_back(mk("rp_arb3",    0, 4'b1000, 4'b1000, 4'b1000, 32'h5000_0000, 0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 1));
        vecs.push_back(mk("rp_g3",      0, 4'b1000, 4'b1000, 4'b1000, 32'h5000_0000, 0, 1, 1, 1, 3, 8'h50, 0, 4'b1000, 3));
        vecs.push_back(mk("idle2",      0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 0, 0, 0, 0, 8'h00, 1, 4'b0000, 3));

        drive(1'b1, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);

        // Table: drive on the falling edge, compare 1 ns later, state advances on the next rising edge.
        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].rst, vecs[n].v, vecs[n].s, vecs[n].e, vecs[n].tags, vecs[n].wr);
            #1;
            check({vecs[n].nm, "/valid"}, avl_valid, vecs[n].ev);
            check({vecs[n].nm, "/sop"},   avl_sop,   vecs[n].es);
            check({vecs[n].nm, "/eop"},   avl_eop,   vecs[n].ee);
            check({vecs[n].nm, "/ready"}, req_ready, vecs[n].erdy);
            check({vecs[n].nm, "/gid"},   grant_id,  vecs[n].egid);
            if (vecs[n].ev) begin
                check({vecs[n].nm, "/data"}, avl_data, word(vecs[n].src, vecs[n].etag));
            end else if (vecs[n].dz) begin
                check({vecs[n].nm, "/data0"}, avl_data, 64'h0);
            end
        end
`ifdef AVL_ARB_STATS_EN
        check("tbl/drop_cnt", drop_cnt, 64'd3);
        check("tbl/pkt_cnt",  pkt_cnt,  64'h0001_0000_0001_0000);
`endif

        // Single-word packets from all four requesters at once.
        do_reset();
        pend = 4'hF;
        cyc  = 0;
        while (pend != 0 && cyc < 40) begin
            @(negedge clk);
            drive(1'b0, 4'(pend), 4'(pend), 4'(pend), 32'h6362_6160, 1'b0);
            #1;
            cyc++;
            if (avl_valid && !avl_waitrequest) begin
                order.push_back(int'(avl_data[15:8]));
                check("sw/sopeop", {avl_sop, avl_eop}, 2'b11);
            end
            pend = pend & ~int'(req_ready);
        end
        check("sw/cycles", cyc, 8);
        check("sw/count", order.size(), 4);
        foreach (order[i]) begin
            check("sw/order", order[i], i);
        end
`ifdef AVL_ARB_STATS_EN
        check("sw/pkt_cnt", pkt_cnt, 64'h0001_0001_0001_0001);
`endif

        // Continuous streaming from requesters 0 and 1: three 2-word packets each.
        do_reset();
        w[0] = 0;
        w[1] = 0;
        k    = 0;
        cyc  = 0;
        while (k < 12 && cyc < 100) begin
            @(negedge clk);
            v = '0; s = '0; e = '0; tags = '0;
            for (int i = 0; i < 2; i++) begin
                v[i] = (w[i] < 6);
                s[i] = (w[i] < 6) && (w[i] % 2 == 0);
                e[i] = (w[i] < 6) && (w[i] % 2 == 1);
                tags[i*8 +: 8] = 8'(w[i]);
            end
            drive(1'b0, v, s, e, tags, 1'b0);
            #1;
            cyc++;
            if (avl_valid && !avl_waitrequest) begin
                pkt = k / 2;
                check("st/data", avl_data, word(pkt % 2, 8'((pkt / 2) * 2 + k % 2)));
                check("st/sop",  avl_sop,  (k % 2 == 0));
                check("st/eop",  avl_eop,  (k % 2 == 1));
                k++;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i] && v[i]) w[i]++;
            end
        end
        check("st/words", k, 12);
        check("st/cycles", cyc, 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
